// File: rtl/mxint8_operand_driver.sv
// MXINT8 operand generator: fills one block of LFSR-derived scales/elements, presents it under
// valid/ready, repeats NUM_TXN times. Optional override build: MXINT8_DRV_SPECIAL_EN.
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 32
`endif
`ifndef SCALE_WIDTH
`define SCALE_WIDTH 8
`endif
`ifndef MXINT8_ELEMENT_WIDTH
`define MXINT8_ELEMENT_WIDTH 8
`endif

module mxint8_operand_driver #(
    parameter int unsigned NUM_TXN = 16,
    parameter logic [31:0] SEED    = 32'hACE1_2345
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  i_start,
    input  logic                                                  i_ready,
    output logic                                                  o_valid,
    output logic [`SCALE_WIDTH-1:0]                               o_scale_a,
    output logic [`SCALE_WIDTH-1:0]                               o_scale_b,
    output logic [`BLOCK_SIZE-1:0][`MXINT8_ELEMENT_WIDTH-1:0]     o_mxint8_elements_a,
    output logic [`BLOCK_SIZE-1:0][`MXINT8_ELEMENT_WIDTH-1:0]     o_mxint8_elements_b,
    output logic [15:0]                                           o_txn_id,
    output logic                                                  o_done
);
    localparam int unsigned BS       = `BLOCK_SIZE;
    localparam int unsigned KW       = (BS > 1) ? $clog2(BS) : 1;
    localparam logic [31:0] LfsrMask = 32'h8020_0003;
    localparam logic [31:0] LfsrInit = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [KW-1:0] KLast  = KW'(BS - 1);
    localparam logic [15:0] TxnLast  = 16'(NUM_TXN - 1);

    typedef enum logic [1:0] {StIdle, StGen, StDrive, StDone} state_e;

    state_e                                              state_q, state_d;
    logic [KW-1:0]                                       k_q, k_d;
    logic [31:0]                                         lfsr_q, lfsr_d;
    logic [15:0]                                         txn_q, txn_d;
    logic [`SCALE_WIDTH-1:0]                             scale_a_q, scale_a_d;
    logic [`SCALE_WIDTH-1:0]                             scale_b_q, scale_b_d;
    logic [BS-1:0][`MXINT8_ELEMENT_WIDTH-1:0]            elem_a_q, elem_a_d;
    logic [BS-1:0][`MXINT8_ELEMENT_WIDTH-1:0]            elem_b_q, elem_b_d;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        lfsr_d    = lfsr_q;
        txn_d     = txn_q;
        scale_a_d = scale_a_q;
        scale_b_d = scale_b_q;
        elem_a_d  = elem_a_q;
        elem_b_d  = elem_b_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StGen;
                    k_d     = '0;
                end
            end
            StGen: begin
                // Fields come from the pre-advance LFSR value.
                elem_a_d[k_q] = lfsr_q[7:0];
                elem_b_d[k_q] = lfsr_q[15:8];
                if (k_q == '0) begin
                    scale_a_d = lfsr_q[23:16];
                    scale_b_d = lfsr_q[31:24];
                end
`ifdef MXINT8_DRV_SPECIAL_EN
                if (txn_q[2:0] == 3'd6) begin
                    elem_a_d[k_q] = 8'h80;
                end
                if (txn_q[2:0] == 3'd7 && k_q == '0) begin
                    scale_a_d = 8'hFF;
                end
`endif
                lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrMask : 32'd0);
                if (k_q == KLast) begin
                    state_d = StDrive;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDrive: begin
                if (i_ready) begin
                    if (txn_q == TxnLast) begin
                        state_d = StDone;
                    end else begin
                        txn_d   = txn_q + 16'd1;
                        k_d     = '0;
                        state_d = StGen;
                    end
                end
            end
            StDone: begin
                if (!i_start) begin
                    state_d = StIdle;
                    txn_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            k_q       <= '0;
            lfsr_q    <= LfsrInit;
            txn_q     <= '0;
            scale_a_q <= '0;
            scale_b_q <= '0;
            elem_a_q  <= '0;
            elem_b_q  <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            lfsr_q    <= lfsr_d;
            txn_q     <= txn_d;
            scale_a_q <= scale_a_d;
            scale_b_q <= scale_b_d;
            elem_a_q  <= elem_a_d;
            elem_b_q  <= elem_b_d;
        end
    end

    assign o_valid             = (state_q == StDrive);
    assign o_done              = (state_q == StDone);
    assign o_txn_id            = txn_q;
    assign o_scale_a           = scale_a_q;
    assign o_scale_b           = scale_b_q;
    assign o_mxint8_elements_a = elem_a_q;
    assign o_mxint8_elements_b = elem_b_q;

endmodule

// File: tb/tb_mxint8_operand_driver.sv
// Randomized bench for mxint8_operand_driver: transaction-level model, per-cycle compare at
// the falling edge, plus literal pins on the seed-derived first block.
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 32
`endif
`ifndef SCALE_WIDTH
`define SCALE_WIDTH 8
`endif
`ifndef MXINT8_ELEMENT_WIDTH
`define MXINT8_ELEMENT_WIDTH 8
`endif

module tb_mxint8_operand_driver;
    localparam int          BS   = `BLOCK_SIZE;
    localparam int          NTXN = 8;
    localparam logic [31:0] SEED = 32'hACE1_2345;
    localparam logic [31:0] MASK = 32'h8020_0003;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_start = 1'b0;
    logic i_ready = 1'b0;

    logic               o_valid, o_done;
    logic [7:0]         o_scale_a, o_scale_b;
    logic [BS-1:0][7:0] o_ea, o_eb;
    logic [15:0]        o_txn_id;

    logic               z_valid, z_done;
    logic [7:0]         z_scale_a, z_scale_b;
    logic [BS-1:0][7:0] z_ea, z_eb;
    logic [15:0]        z_txn_id;
    logic               z_ready = 1'b1;

    mxint8_operand_driver #(.NUM_TXN(NTXN), .SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_ready(i_ready),
        .o_valid(o_valid), .o_scale_a(o_scale_a), .o_scale_b(o_scale_b),
        .o_mxint8_elements_a(o_ea), .o_mxint8_elements_b(o_eb),
        .o_txn_id(o_txn_id), .o_done(o_done)
    );

    // Zero seed must be replaced by 1.
    mxint8_operand_driver #(.NUM_TXN(1), .SEED(32'd0)) dut_z (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_ready(z_ready),
        .o_valid(z_valid), .o_scale_a(z_scale_a), .o_scale_b(z_scale_b),
        .o_mxint8_elements_a(z_ea), .o_mxint8_elements_b(z_eb),
        .o_txn_id(z_txn_id), .o_done(z_done)
    );

    always #5 clk = ~clk;

    logic [31:0]        m_lfsr;
    logic               exp_valid, exp_done;
    logic [15:0]        exp_txn;
    logic [7:0]         exp_sa, exp_sb;
    logic [BS-1:0][7:0] exp_ea, exp_eb;
    bit chk_en = 0, chk_data = 0, chk_z = 0;
    int n_tests = 0, n_fail = 0;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ MASK) : (x >> 1);
    endfunction

    task automatic check(input string name, input logic [BS*8-1:0] act, input logic [BS*8-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: sole owner of the counters.
    initial begin
        check("pin_lfsr_step_1", lfsr_next(32'h1), 32'h8020_0003);
        check("pin_lfsr_step_2", lfsr_next(32'h2), 32'h1);
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("valid", o_valid, exp_valid);
                check("done", o_done, exp_done);
                check("txn_id", o_txn_id, exp_txn);
                if (chk_data) begin
                    check("scale_a", o_scale_a, exp_sa);
                    check("scale_b", o_scale_b, exp_sb);
                    check("elem_a", o_ea, exp_ea);
                    check("elem_b", o_eb, exp_eb);
                end
            end
            if (chk_z) begin
                check("pin_model_scale_a", exp_sa, 8'hE1);
                check("first_scale_a", o_scale_a, 8'hE1);
                check("first_scale_b", o_scale_b, 8'hAC);
                check("first_elem_a0", o_ea[0], 8'h45);
                check("first_elem_b0", o_eb[0], 8'h23);
                check("zseed_valid", z_valid, 1'b1);
                check("zseed_scale_a", z_scale_a, 8'h00);
                check("zseed_elem_a0", z_ea[0], 8'h01);
                check("zseed_elem_a1", z_ea[1], 8'h03);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_exp();
        exp_valid = 0; exp_done = 0; exp_txn = '0;
        exp_sa = '0; exp_sb = '0; exp_ea = '0; exp_eb = '0;
        m_lfsr = SEED; chk_data = 1;
    endtask

    task automatic build_txn(input logic [15:0] txn);
        for (int k = 0; k < BS; k++) begin
            exp_ea[k] = m_lfsr[7:0];
            exp_eb[k] = m_lfsr[15:8];
            if (k == 0) begin
                exp_sa = m_lfsr[23:16];
                exp_sb = m_lfsr[31:24];
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
`ifdef MXINT8_DRV_SPECIAL_EN
        if (txn[2:0] == 3'd6) exp_ea = {BS{8'h80}};
        if (txn[2:0] == 3'd7) exp_sa = 8'hFF;
`endif
    endtask

    // Called right after the edge that enters GEN; returns right after the edge entering DRIVE.
    task automatic gen_phase();
        exp_valid = 0; chk_data = 0;
        build_txn(exp_txn);
        for (int i = 0; i < BS; i++) begin
            i_ready = 1'($urandom_range(0, 1));
            i_start = 1'($urandom_range(0, 1));
            tick();
        end
        exp_valid = 1; chk_data = 1;
    endtask

    task automatic run(input int first_stall, input bit first_run);
        i_start = 1; tick();
        for (int t = 0; t < NTXN; t++) begin
            int stall;
            gen_phase();
            if (t == 0 && first_run) chk_z = 1;
            stall = (t == 0) ? first_stall : int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                i_ready = 0;
                i_start = 1'($urandom_range(0, 1));
                tick();
                chk_z = 0;
            end
            i_ready = 1; tick();
            chk_z = 0;
            exp_valid = 0;
            if (t == NTXN - 1) exp_done = 1;
            else exp_txn = exp_txn + 16'd1;
        end
        i_ready = 1'($urandom_range(0, 1));
        i_start = 1; tick(); tick();
        i_start = 0; tick();
        exp_done = 0; exp_txn = '0;
        tick();
    endtask

    initial begin
        rst_n = 0; i_start = 0; i_ready = 0;
        tick(); tick();
        reset_exp(); chk_en = 1;
        tick();
        rst_n = 1; tick(); tick();

        run(10, 1);
        run(0, 0);

        // Reset in the middle of GEN (k=15).
        i_start = 1; tick();
        exp_valid = 0; chk_data = 0;
        for (int i = 0; i < 15; i++) tick();
        rst_n = 0; tick();
        reset_exp();
        rst_n = 1; i_start = 0; tick();
        run(2, 0);

        // Reset in the middle of DRIVE, with i_ready high on the reset edge.
        i_start = 1; tick();
        gen_phase();
        i_ready = 0; tick(); tick(); tick();
        rst_n = 0; i_ready = 1; tick();
        reset_exp();
        rst_n = 1; i_ready = 0; i_start = 0; tick();
        run(1, 0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
